// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 set-2 definitions.
//   Scancode constants, modifier encoding, the encoder FSM state type and the
//   lookup-result struct. Shareable with scancode_convert.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_LCTRL  = 8'h14;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  typedef enum logic [1:0] {
    MOD_NONE  = 2'd0,
    MOD_SHIFT = 2'd1,
    MOD_CTRL  = 2'd2
  } mod_e;

  typedef enum logic [2:0] {
    IDLE,
    MOD_MK,
    KEY_MK,
    KEY_PF,
    KEY_BK,
    MOD_PF,
    MOD_BK,
    GAP
  } ps2_state_e;

  // Scancode of the modifier key itself.
  function automatic logic [7:0] mod_code(input mod_e m);
    logic [7:0] c;
    case (m)
      MOD_SHIFT: c = SC_LSHIFT;
      MOD_CTRL:  c = SC_LCTRL;
      default:   c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ascii_scancode_rom.sv
// ascii_scancode_rom: combinational ASCII -> PS/2 set-2 lookup (US layout).
//   ascii  in  8  character code; bit 7 set is always unmapped
//   valid  out 1  character has a keystroke mapping
//   mod    out 2  modifier required (none/shift/ctrl)
//   code   out 8  make code of the base key
import ps2_pkg::*;

module ascii_scancode_rom (
  input  logic [7:0] ascii,
  output logic       valid,
  output mod_e       mod,
  output logic [7:0] code
);

  function automatic logic [7:0] letter_code(input logic [4:0] idx);
    logic [7:0] c;
    case (idx)
      5'd0:  c = 8'h1C; 5'd1:  c = 8'h32; 5'd2:  c = 8'h21; 5'd3:  c = 8'h23;
      5'd4:  c = 8'h24; 5'd5:  c = 8'h2B; 5'd6:  c = 8'h34; 5'd7:  c = 8'h33;
      5'd8:  c = 8'h43; 5'd9:  c = 8'h3B; 5'd10: c = 8'h42; 5'd11: c = 8'h4B;
      5'd12: c = 8'h3A; 5'd13: c = 8'h31; 5'd14: c = 8'h44; 5'd15: c = 8'h4D;
      5'd16: c = 8'h15; 5'd17: c = 8'h2D; 5'd18: c = 8'h1B; 5'd19: c = 8'h2C;
      5'd20: c = 8'h3C; 5'd21: c = 8'h2A; 5'd22: c = 8'h1D; 5'd23: c = 8'h22;
      5'd24: c = 8'h35; 5'd25: c = 8'h1A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [6:0] a7;
  logic       sh;

  always_comb begin
    a7    = ascii[6:0];
    valid = 1'b1;
    mod   = MOD_NONE;
    code  = 8'h00;
    sh    = 1'b0;
    if (a7 >= 7'h61 && a7 <= 7'h7A) begin
      code = letter_code(5'(a7 - 7'h61));
    end else if (a7 >= 7'h41 && a7 <= 7'h5A) begin
      sh   = 1'b1;
      code = letter_code(5'(a7 - 7'h41));
    end else begin
      case (a7)
        7'h08: code = SC_BKSP;
        7'h09: code = SC_TAB;
        7'h0D: code = SC_ENTER;
        7'h1B: code = SC_ESC;
        7'h20: code = SC_SPACE;
        7'h30: code = 8'h45; 7'h31: code = 8'h16; 7'h32: code = 8'h1E; 7'h33: code = 8'h26;
        7'h34: code = 8'h25; 7'h35: code = 8'h2E; 7'h36: code = 8'h36; 7'h37: code = 8'h3D;
        7'h38: code = 8'h3E; 7'h39: code = 8'h46;
        7'h27: code = 8'h52; 7'h2C: code = 8'h41; 7'h2D: code = 8'h4E; 7'h2E: code = 8'h49;
        7'h2F: code = 8'h4A; 7'h3B: code = 8'h4C; 7'h3D: code = 8'h55; 7'h5B: code = 8'h54;
        7'h5C: code = 8'h5D; 7'h5D: code = 8'h5B; 7'h60: code = 8'h0E;
        7'h21: {sh, code} = {1'b1, 8'h16};
        7'h22: {sh, code} = {1'b1, 8'h52};
        7'h23: {sh, code} = {1'b1, 8'h26};
        7'h24: {sh, code} = {1'b1, 8'h25};
        7'h25: {sh, code} = {1'b1, 8'h2E};
        7'h26: {sh, code} = {1'b1, 8'h3D};
        7'h28: {sh, code} = {1'b1, 8'h46};
        7'h29: {sh, code} = {1'b1, 8'h45};
        7'h2A: {sh, code} = {1'b1, 8'h3E};
        7'h2B: {sh, code} = {1'b1, 8'h55};
        7'h3A: {sh, code} = {1'b1, 8'h4C};
        7'h3C: {sh, code} = {1'b1, 8'h41};
        7'h3E: {sh, code} = {1'b1, 8'h49};
        7'h3F: {sh, code} = {1'b1, 8'h4A};
        7'h40: {sh, code} = {1'b1, 8'h1E};
        7'h5E: {sh, code} = {1'b1, 8'h36};
        7'h5F: {sh, code} = {1'b1, 8'h4E};
        7'h7B: {sh, code} = {1'b1, 8'h54};
        7'h7C: {sh, code} = {1'b1, 8'h5D};
        7'h7D: {sh, code} = {1'b1, 8'h5B};
        7'h7E: {sh, code} = {1'b1, 8'h0E};
        default: begin
          // Remaining C0 controls 0x01-0x1A are ctrl + letter.
          if (a7 >= 7'h01 && a7 <= 7'h1A) begin
            mod  = MOD_CTRL;
            code = letter_code(5'(a7 - 7'h01));
          end else begin
            valid = 1'b0;
          end
        end
      endcase
    end
    if (sh) mod = MOD_SHIFT;
    if (ascii[7]) begin
      valid = 1'b0;
      mod   = MOD_NONE;
      code  = 8'h00;
    end
  end

endmodule

// File: rtl/ascii_to_scancode.sv
// ascii_to_scancode: one ASCII character per strobe -> PS/2 set-2 byte stream
//   (modifier make, key make, key break, modifier break) with valid/ready output.
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   ascii      in   character, sampled on strobe_in while idle
//   strobe_in  in   one-cycle encode request
//   busy       out  sequence in progress (including trailing gap)
//   scancode   out  current byte, stable while out_valid
//   out_valid  out  scancode valid
//   out_ready  in   sink accepts byte on out_valid & out_ready
//   error      out  one-cycle pulse: unmapped char or strobe while busy
import ps2_pkg::*;

module ascii_to_scancode #(
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          EMIT_BREAK = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ascii,
  input  logic       strobe_in,
  output logic       busy,
  output logic [7:0] scancode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       error
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic       rom_valid;
  mod_e       rom_mod;
  logic [7:0] rom_code;

  ascii_scancode_rom u_rom (
    .ascii (ascii),
    .valid (rom_valid),
    .mod   (rom_mod),
    .code  (rom_code)
  );

  ps2_state_e      state_q, after_q;
  mod_e            mod_q;
  logic [7:0]      code_q;
  logic [GapW-1:0] gap_q;
  logic            busy_q, valid_q, err_q;
  logic [7:0]      sc_q;

  function automatic ps2_state_e next_emit(input ps2_state_e st, input mod_e m);
    ps2_state_e n;
    case (st)
      MOD_MK:  n = KEY_MK;
      KEY_MK:  n = EMIT_BREAK ? KEY_PF : IDLE;
      KEY_PF:  n = KEY_BK;
      KEY_BK:  n = (m != MOD_NONE) ? MOD_PF : IDLE;
      MOD_PF:  n = MOD_BK;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] state_byte(input ps2_state_e st, input mod_e m,
                                            input logic [7:0] c);
    logic [7:0] b;
    case (st)
      MOD_MK, MOD_BK: b = mod_code(m);
      KEY_PF, MOD_PF: b = SC_BREAK;
      default:        b = c;
    endcase
    return b;
  endfunction

  logic       emitting, do_gap, do_adv;
  ps2_state_e adv_state, first_state;
  logic [7:0] adv_byte;

  always_comb begin
    emitting    = (state_q != IDLE) && (state_q != GAP);
    do_gap      = emitting && out_ready && (GAP_CYCLES > 0);
    do_adv      = (state_q == GAP) ? (gap_q == '0)
                                   : (emitting && out_ready && (GAP_CYCLES == 0));
    adv_state   = (state_q == GAP) ? after_q : next_emit(state_q, mod_q);
    adv_byte    = state_byte(adv_state, mod_q, code_q);
    first_state = (rom_mod != MOD_NONE) ? MOD_MK : KEY_MK;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      after_q <= IDLE;
      mod_q   <= MOD_NONE;
      code_q  <= 8'h00;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sc_q    <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == IDLE) begin
        if (strobe_in) begin
          if (rom_valid) begin
            state_q <= first_state;
            mod_q   <= rom_mod;
            code_q  <= rom_code;
            sc_q    <= state_byte(first_state, rom_mod, rom_code);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
      end else begin
        // Busy: any new request is dropped and flagged.
        if (strobe_in) err_q <= 1'b1;
        if (do_gap) begin
          state_q <= GAP;
          after_q <= adv_state;
          gap_q   <= GapW'(GAP_CYCLES - 1);
          valid_q <= 1'b0;
        end else if (do_adv) begin
          if (adv_state == IDLE) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= adv_state;
            sc_q    <= adv_byte;
            valid_q <= 1'b1;
          end
        end else if (state_q == GAP) begin
          gap_q <= gap_q - GapW'(1);
        end
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign scancode  = sc_q;
  assign error     = err_q;

endmodule

// File: tb/tb_ascii_to_scancode.sv
// tb_ascii_to_scancode: three encoder instances (no gap, 3-cycle gap, make-only)
// share one stimulus stream and are checked every cycle against a queue model.
module tb_ascii_to_scancode;

  logic       clock, reset, strobe_in, out_ready;
  logic [7:0] ascii;
  logic       busy_w [3];
  logic       out_valid_w [3];
  logic       err_w [3];
  logic [7:0] sc_w [3];

  ascii_to_scancode #(.GAP_CYCLES(0), .EMIT_BREAK(1'b1)) u_dut0 (
    .clock(clock), .reset(reset), .ascii(ascii), .strobe_in(strobe_in),
    .busy(busy_w[0]), .scancode(sc_w[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .error(err_w[0]));
  ascii_to_scancode #(.GAP_CYCLES(3), .EMIT_BREAK(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .ascii(ascii), .strobe_in(strobe_in),
    .busy(busy_w[1]), .scancode(sc_w[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .error(err_w[1]));
  ascii_to_scancode #(.GAP_CYCLES(0), .EMIT_BREAK(1'b0)) u_dut2 (
    .clock(clock), .reset(reset), .ascii(ascii), .strobe_in(strobe_in),
    .busy(busy_w[2]), .scancode(sc_w[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .error(err_w[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- keyboard layout model ----------------
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46};
  logic [7:0] punct_sc [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                8'h41, 8'h49, 8'h4A};
  logic [7:0] unsh_p [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                              8'h2C, 8'h2E, 8'h2F};
  logic [7:0] sh_p [11]   = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                              8'h3C, 8'h3E, 8'h3F};
  string sh_d   = ")!@#$%^&*(";

  function automatic void model_key(input logic [7:0] c, output bit ok,
                                    output logic [7:0] modb, output logic [7:0] key);
    ok = 1'b1; modb = 8'h00; key = 8'h00;
    if (c >= 8'h61 && c <= 8'h7A) key = letter_sc[int'(c) - 'h61];
    else if (c >= 8'h41 && c <= 8'h5A) begin modb = 8'h12; key = letter_sc[int'(c) - 'h41]; end
    else if (c >= 8'h30 && c <= 8'h39) key = digit_sc[int'(c) - 'h30];
    else if (c == 8'h20) key = 8'h29;
    else if (c == 8'h08) key = 8'h66;
    else if (c == 8'h09) key = 8'h0D;
    else if (c == 8'h0D) key = 8'h5A;
    else if (c == 8'h1B) key = 8'h76;
    else if (c >= 8'h01 && c <= 8'h1A) begin modb = 8'h14; key = letter_sc[int'(c) - 1]; end
    else begin
      ok = 1'b0;
      for (int i = 0; i < 11; i++) begin
        if (c == unsh_p[i]) begin ok = 1'b1; key = punct_sc[i]; end
        if (c == sh_p[i]) begin ok = 1'b1; modb = 8'h12; key = punct_sc[i]; end
      end
      for (int i = 0; i < 10; i++)
        if (c == sh_d[i]) begin ok = 1'b1; modb = 8'h12; key = digit_sc[i]; end
    end
  endfunction

  function automatic int gap_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  // ---------------- cycle model: pending-byte queue per instance ----------------
  logic [7:0] mbuf [3][6];
  int  mhead [3] = '{0, 0, 0};
  int  mlen  [3] = '{0, 0, 0};
  int  mgap  [3] = '{0, 0, 0};
  bit  mvalid [3] = '{0, 0, 0};
  bit  mbusy  [3] = '{0, 0, 0};
  bit  merr   [3] = '{0, 0, 0};

  task automatic model_reset(input int d);
    mhead[d] = 0; mlen[d] = 0; mgap[d] = 0;
    mvalid[d] = 0; mbusy[d] = 0; merr[d] = 0;
  endtask

  task automatic model_step(input int d, input bit stb, input logic [7:0] a, input bit rdy);
    bit old_busy;
    bit ok;
    logic [7:0] mb, k;
    old_busy = mbusy[d];
    model_key(a, ok, mb, k);
    merr[d] = stb && (old_busy || !ok);
    if (mvalid[d] && rdy) begin
      mhead[d]++; mlen[d]--;
      if (gap_of(d) > 0) begin
        mvalid[d] = 0; mgap[d] = gap_of(d);
      end else begin
        mvalid[d] = mlen[d] > 0; mbusy[d] = mlen[d] > 0;
      end
    end else if (mgap[d] > 0) begin
      mgap[d]--;
      if (mgap[d] == 0) begin mvalid[d] = mlen[d] > 0; mbusy[d] = mlen[d] > 0; end
    end
    if (stb && !old_busy && ok) begin
      mhead[d] = 0;
      mbuf[d][0] = (mb != 0) ? mb : k;
      mbuf[d][1] = k;
      if (d == 2) mlen[d] = (mb != 0) ? 2 : 1;
      else if (mb != 0) begin
        mbuf[d][2] = 8'hF0; mbuf[d][3] = k; mbuf[d][4] = 8'hF0; mbuf[d][5] = mb;
        mlen[d] = 6;
      end else begin
        mbuf[d][1] = 8'hF0; mbuf[d][2] = k;
        mlen[d] = 3;
      end
      mvalid[d] = 1; mbusy[d] = 1;
    end
  endtask

  // ---------------- observation logs ----------------
  logic [7:0] log0 [$];
  logic [7:0] log2 [$];
  logic [7:0] exp_q [$];
  int gaps1 [$];
  int run1 = 0;
  int busy_cnt0 = 0;
  int err_cnt0 = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid_w[0] && out_ready) log0.push_back(sc_w[0]);
      if (out_valid_w[2] && out_ready) log2.push_back(sc_w[2]);
      if (busy_w[0]) busy_cnt0++;
      if (err_w[0]) err_cnt0++;
      if (busy_w[1] && !out_valid_w[1]) run1++;
      else if (out_valid_w[1]) begin
        if (run1 > 0) gaps1.push_back(run1);
        run1 = 0;
      end else run1 = 0;
    end else run1 = 0;
    for (int d = 0; d < 3; d++) begin
      if (reset) model_reset(d);
      chk($sformatf("d%0d out_valid", d), 32'(out_valid_w[d]), 32'(mvalid[d]));
      chk($sformatf("d%0d busy", d), 32'(busy_w[d]), 32'(mbusy[d]));
      chk($sformatf("d%0d error", d), 32'(err_w[d]), 32'(merr[d]));
      if (mvalid[d]) chk($sformatf("d%0d scancode", d), 32'(sc_w[d]), 32'(mbuf[d][mhead[d]]));
      else if (reset) chk($sformatf("d%0d reset scancode", d), 32'(sc_w[d]), 32'h0);
      if (!reset) model_step(d, strobe_in, ascii, out_ready);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    strobe_in = 1'b1;
    ascii = c;
    tick();
    strobe_in = 1'b0;
  endtask

  function automatic bit any_active();
    return busy_w[0] | busy_w[1] | busy_w[2] | out_valid_w[0] | out_valid_w[1] | out_valid_w[2];
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (any_active() && n < 400) begin tick(); n++; end
    chk("idle_timeout", 32'(n < 400), 32'h1);
  endtask

  task automatic chk_log(input string name, input int sel);
    logic [7:0] got [$];
    got = (sel == 0) ? log0 : log2;
    chk({name, " len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s byte%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  function automatic int decode(input logic [7:0] mb, input logic [7:0] k);
    bit ok;
    logic [7:0] m2, k2;
    for (int x = 1; x < 127; x++) begin
      model_key(8'(x), ok, m2, k2);
      if (ok && m2 == mb && k2 == k) return x;
    end
    return -1;
  endfunction

  initial begin
    bit ok;
    logic [7:0] mb, k;
    int e0;
    reset = 1'b1; strobe_in = 1'b0; ascii = 8'h00; out_ready = 1'b1;
    tick(); tick();
    chk("reset busy", 32'(busy_w[0]), 32'h0);
    chk("reset out_valid", 32'(out_valid_w[0]), 32'h0);
    chk("reset scancode", 32'(sc_w[0]), 32'h0);
    chk("reset error", 32'(err_w[0]), 32'h0);
    reset = 1'b0;
    tick();

    // Pin the layout model with hand-derived codes.
    model_key(8'h61, ok, mb, k); chk("model a", {ok, 7'd0, mb, k}, 32'h80_00_1C);
    model_key(8'h41, ok, mb, k); chk("model A", {ok, 7'd0, mb, k}, 32'h80_12_1C);
    model_key(8'h03, ok, mb, k); chk("model ^C", {ok, 7'd0, mb, k}, 32'h80_14_21);
    model_key(8'h21, ok, mb, k); chk("model !", {ok, 7'd0, mb, k}, 32'h80_12_16);
    model_key(8'h31, ok, mb, k); chk("model 1", {ok, 7'd0, mb, k}, 32'h80_00_16);
    model_key(8'h0D, ok, mb, k); chk("model CR", {ok, 7'd0, mb, k}, 32'h80_00_5A);
    model_key(8'h1F, ok, mb, k); chk("model 1F", 32'(ok), 32'h0);
    model_key(8'h80, ok, mb, k); chk("model 80", 32'(ok), 32'h0);

    // 'a' back-to-back
    log0.delete(); busy_cnt0 = 0;
    send(8'h61); wait_idle();
    exp_q = {8'h1C, 8'hF0, 8'h1C}; chk_log("a seq", 0);
    chk("a busy cycles", 32'(busy_cnt0), 32'd3);

    log0.delete(); log2.delete();
    send(8'h41); wait_idle();
    exp_q = {8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12}; chk_log("A seq", 0);
    exp_q = {8'h12, 8'h1C}; chk_log("A makeonly", 2);
    log0.delete();
    send(8'h03); wait_idle();
    exp_q = {8'h14, 8'h21, 8'hF0, 8'h21, 8'hF0, 8'h14}; chk_log("ctrlC seq", 0);
    log0.delete();
    send(8'h0D); wait_idle();
    exp_q = {8'h5A, 8'hF0, 8'h5A}; chk_log("CR seq", 0);

    // unmapped
    log0.delete(); e0 = err_cnt0;
    send(8'h80); tick(); send(8'h1F); tick(); wait_idle();
    chk("unmapped errors", 32'(err_cnt0 - e0), 32'd2);
    chk("unmapped bytes", 32'(log0.size()), 32'd0);

    // 'A' with random backpressure
    log0.delete();
    send(8'h41);
    for (int n = 0; n < 600 && any_active(); n++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
    exp_q = {8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12}; chk_log("A backpressure", 0);

    // strobe while busy; gap measured on the GAP_CYCLES=3 instance
    log0.delete(); gaps1.delete(); e0 = err_cnt0;
    send(8'h41); tick(); send(8'h62); wait_idle();
    chk_log("A with drop", 0);
    chk("busy strobe error", 32'(err_cnt0 - e0), 32'd1);
    chk("gap count", 32'(gaps1.size()), 32'd5);
    foreach (gaps1[i]) chk($sformatf("gap%0d len", i), 32'(gaps1[i]), 32'd3);

    // reset while the F0 of 'a' is pending
    out_ready = 1'b0;
    send(8'h61);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre-reset F0 pending", {24'd0, out_valid_w[0], sc_w[0][6:0]}, 32'h0000_00F0);
    reset = 1'b1;
    #1;
    chk("mid reset out_valid", 32'(out_valid_w[0]), 32'h0);
    chk("mid reset busy", 32'(busy_w[0]), 32'h0);
    tick();
    reset = 1'b0; out_ready = 1'b1;
    tick();
    log0.delete();
    send(8'h61); wait_idle();
    exp_q = {8'h1C, 8'hF0, 8'h1C}; chk_log("a after reset", 0);

    // Loopback sweep: decode dut0's bytes back to the character.
    for (int c = 0; c < 130; c++) begin
      logic [7:0] code;
      code = (c < 128) ? 8'(c) : ((c == 128) ? 8'h80 : 8'hFF);
      log0.delete();
      send(code); wait_idle();
      model_key(code, ok, mb, k);
      if (!ok) chk($sformatf("sweep %0h silent", code), 32'(log0.size()), 32'd0);
      else if (log0.size() == 3) chk($sformatf("loopback %0h", code), 32'(decode(8'h00, log0[0])), 32'(code));
      else if (log0.size() == 6) chk($sformatf("loopback %0h", code), 32'(decode(log0[0], log0[1])), 32'(code));
      else chk($sformatf("loopback %0h len", code), 32'(log0.size()), (mb != 0) ? 32'd6 : 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascii_to_scancode.md
Name: ascii_to_scancode

Overview:
- Inverse of scancode_convert: takes one ASCII character per strobe and emits the PS/2 set-2 scancode byte sequence a keyboard would send for that keystroke: modifier make, key make, key break, modifier break.
- Sits between a character source (front-panel/console test logic, host stimulus) and a byte sink: a PS/2 device-side transmitter, or scancode_convert directly for loopback testing.

Parameters:
- GAP_CYCLES, 0, idle clocks inserted after each accepted output byte before the next byte is offered (0 = back-to-back).
- EMIT_BREAK, 1, 1 = emit F0-prefixed break codes; 0 = make codes only (modifier make still precedes key make).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- ascii  input  8  character code; sampled only when strobe_in=1 and busy=0.
- strobe_in  input  1  one-cycle request to encode ascii.
- busy  output  1  high from the cycle after acceptance until the last byte is accepted (and any trailing gap has elapsed).
- scancode  output  8  current output byte; stable while out_valid=1.
- out_valid  output  1  scancode valid.
- out_ready  input  1  sink accepts the byte when out_valid and out_ready are both 1 on a clock edge.
- error  output  1  one-cycle pulse: unmapped character, or strobe_in while busy.

Behaviour:
- Reset values: busy=0, out_valid=0, scancode=8'h00, error=0, FSM=IDLE, gap counter=0.
- Lookup, combinational, returns {valid, mod[1:0], code[7:0]}. mod: 0=none, 1=shift (12), 2=ctrl (14).
- Unshifted printable: a-z, 0-9, space=29, punctuation per US layout, e.g. a=1C, c=21, 1=16.
- Shifted printable: A-Z and shifted punctuation, e.g. A=12+1C, !=12+16.
- Named control codes: 0x08=66, 0x09=0D, 0x0D=5A, 0x1B=76.
- Other 0x01-0x1A: ctrl + letter, e.g. 0x03 = 14+21.
- Unmapped: 0x00, 0x1C-0x1F, 0x7F-0xFF.
- Acceptance: strobe_in=1 and busy=0 in IDLE latches ascii and the lookup result.
  - Mapped: FSM leaves IDLE, busy=1 next cycle, first byte presented with out_valid=1 that same next cycle.
  - Unmapped: error pulses next cycle, no bytes emitted, FSM stays IDLE, busy stays 0.
- strobe_in while busy=1: request dropped, error pulses next cycle, current sequence unaffected.
- FSM states: IDLE, MOD_MK, KEY_MK, KEY_PF, KEY_BK, MOD_PF, MOD_BK, GAP.
  - Entry from IDLE: MOD_MK if mod!=0, else KEY_MK.
  - Order: MOD_MK -> KEY_MK -> KEY_PF (F0) -> KEY_BK -> MOD_PF (F0, only if mod!=0) -> MOD_BK -> IDLE.
  - EMIT_BREAK=0: sequence ends after KEY_MK.
  - Each emitting state holds scancode and out_valid until a handshake occurs; out_ready is ignored while out_valid=0.
  - After each handshake, if GAP_CYCLES>0: out_valid=0 for exactly GAP_CYCLES clocks (GAP state, counter), then the next state.
  - Handshake on the final byte: busy=0 next cycle (after the gap if GAP_CYCLES>0). A new strobe_in is acceptable that same cycle.
- Byte counts: unmodified key 3 bytes, modified key 6 bytes; EMIT_BREAK=0 gives 1 and 2.
- Throughput with GAP_CYCLES=0 and out_ready held 1: one byte per clock.
- Reset mid-sequence: immediate return to reset values; no partial sequence resumes after reset deasserts.
- out_valid never drops without a handshake, except on reset.

Decomposition:
- Shared package ps2_pkg:
  - Scancode constants: SC_BREAK=8'hF0, SC_LSHIFT=8'h12, SC_LCTRL=8'h14, SC_ENTER, SC_BKSP, SC_TAB, SC_ESC.
  - Modifier enum (MOD_NONE/MOD_SHIFT/MOD_CTRL).
  - FSM state encoding, shareable with scancode_convert.
- Sub-module ascii_scancode_rom: purely combinational 128-entry case table (ascii[6:0] -> valid, mod, code); bit 7 set forces valid=0.
- The FSM, gap counter and handshake stay in ascii_to_scancode.

Test Plan:
- 0x61 'a', out_ready=1, GAP_CYCLES=0 -> bytes 1C, F0, 1C on three consecutive clocks; busy high 3 cycles; error=0.
- 0x41 'A' -> 12, 1C, F0, 1C, F0, 12; then 0x03 -> 14, 21, F0, 21, F0, 14; then 0x0D -> 5A, F0, 5A.
- 0x80, then 0x1F -> error pulse each, out_valid never asserts, busy stays 0.
- 'A' with out_ready toggling pseudo-randomly -> identical 6-byte sequence; scancode stable while out_valid=1 and out_ready=0.
- strobe_in with 0x62 during the 'A' sequence -> error pulse, 'A' sequence unchanged, no 32 emitted. GAP_CYCLES=3 -> exactly 3 out_valid=0 cycles between bytes.
- Assert reset while KEY_PF is pending -> out_valid=0 and busy=0 immediately. After release, 0x61 -> clean 1C, F0, 1C.
- Loopback into scancode_convert over all mapped codes 0x01-0x7E -> recovered ascii equals input.
